// File: rtl/mac_host_driver_if.sv
// Host handshake and MAC chip pin bundle for mac_host_driver.
// master = the driver itself, slave = host/chip environment.
interface mac_host_driver_if;
    logic        start_req;
    logic        pair_valid;
    logic        pair_ready;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic [19:0] result;
    logic        result_carry;
    logic        result_valid;
    logic        busy;
    logic        error;
    logic        chip_start;
    logic        chip_shift_a;
    logic        chip_shift_b;
    logic        chip_shift;
    logic        chip_do_next;
    logic        chip_finish;
    logic        chip_end_mul;
    logic        chip_shiftout;
    logic        chip_carry;

    modport master (
        input  start_req, pair_valid, op_a, op_b,
               chip_finish, chip_end_mul, chip_shiftout, chip_carry,
        output pair_ready, result, result_carry, result_valid, busy, error,
               chip_start, chip_shift_a, chip_shift_b, chip_shift, chip_do_next
    );

    modport slave (
        output start_req, pair_valid, op_a, op_b,
               chip_finish, chip_end_mul, chip_shiftout, chip_carry,
        input  pair_ready, result, result_carry, result_valid, busy, error,
               chip_start, chip_shift_a, chip_shift_b, chip_shift, chip_do_next
    );
endinterface

// File: rtl/mac_host_driver.sv
// Host-side sequencer for the serial MAC chip: serializes ten operand
// pairs, strobes start/do-next, follows end-mul/finish, then shifts the
// 20-bit accumulated result back out LSB first.
module mac_host_driver #(
    parameter int SHIFT_HOLD = 2,
    parameter int GUARD      = 4,
    parameter int WDOG       = 255
) (
    input logic               clock,
    input logic               reset,
    mac_host_driver_if.master bus
);
    localparam int N_PAIRS = 10;
    localparam int PW      = (SHIFT_HOLD > 1) ? $clog2(SHIFT_HOLD) : 1;
    localparam int WMAX    = (WDOG > GUARD) ? WDOG : GUARD;
    localparam int WW      = $clog2(WMAX + 2);

    localparam logic [PW-1:0] PH_LAST = PW'(SHIFT_HOLD - 1);
    localparam logic [WW-1:0] W_LAST  = WW'(WDOG);
    localparam logic [WW-1:0] G_LAST  = WW'(GUARD - 1);
    localparam logic [3:0]    P_LAST  = 4'(N_PAIRS - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_SHIFT, S_START, S_NEXT, S_WAIT_LO,
        S_WAIT_HI, S_GUARD, S_WAIT_FIN, S_READ, S_DONE, S_ERR
    } state_t;

    state_t state, state_nx;

    logic [3:0]    pair_idx;
    logic [4:0]    bit_idx;
    logic [PW-1:0] ph_cnt;
    logic          hi;         // chip_shift high phase of current bit
    logic          lead;       // one low setup/sample cycle before first rise
    logic [WW-1:0] wcnt;       // watchdog / guard / settle counter
    logic          fin_seen;
    logic [7:0]    sh_a, sh_b; // MSB drives the data pins
    logic [19:0]   res_q;
    logic          carry_q;
    logic          rv_q;

    logic          ph_end, lo_end, ser_done, start_ok, wd_trip, fin_hit, enter_ser;
    logic [4:0]    bits_last;

    assign ph_end    = (ph_cnt == PH_LAST);
    assign lo_end    = !hi && !lead && ph_end;
    assign bits_last = (state == S_READ) ? 5'd19 : 5'd7;
    assign ser_done  = lo_end && (bit_idx == bits_last);
    assign start_ok  = bus.start_req && (state == S_IDLE || state == S_ERR);
    assign wd_trip   = (wcnt == W_LAST);
    assign fin_hit   = (state == S_WAIT_FIN) && !fin_seen && bus.chip_finish;
    assign enter_ser = (state_nx == S_SHIFT && state != S_SHIFT) ||
                       (state_nx == S_READ  && state != S_READ);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Next-state decode; every wait state falls to ERR once the watchdog trips.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE, S_ERR: if (bus.start_req) state_nx = S_LOAD;
            S_LOAD:        if (bus.pair_valid) state_nx = S_SHIFT;
            S_SHIFT:       if (ser_done) state_nx = (pair_idx == 4'd0) ? S_START : S_NEXT;
            S_START,
            S_NEXT:        state_nx = S_WAIT_LO;
            S_WAIT_LO: begin
                if (!bus.chip_end_mul) state_nx = S_WAIT_HI;
                else if (wd_trip)      state_nx = S_ERR;
            end
            S_WAIT_HI: begin
                if (bus.chip_end_mul) state_nx = (pair_idx == P_LAST) ? S_WAIT_FIN : S_GUARD;
                else if (wd_trip)     state_nx = S_ERR;
            end
            S_GUARD:       if (wcnt == G_LAST) state_nx = S_LOAD;
            S_WAIT_FIN: begin
                // two settle cycles after finish so the chip has loaded its result
                if (fin_seen) begin
                    if (wcnt == WW'(1)) state_nx = S_READ;
                end else if (!bus.chip_finish && wd_trip) begin
                    state_nx = S_ERR;
                end
            end
            S_READ:        if (ser_done) state_nx = S_DONE;
            S_DONE:        state_nx = S_IDLE;
            default:       state_nx = S_IDLE;
        endcase
    end

    // Bit-serial engine, wait counter, pair index and operand shifters.
    always_ff @(posedge clock) begin
        if (reset) begin
            pair_idx <= '0;
            bit_idx  <= '0;
            ph_cnt   <= '0;
            hi       <= 1'b0;
            lead     <= 1'b0;
            wcnt     <= '0;
            fin_seen <= 1'b0;
            sh_a     <= '0;
            sh_b     <= '0;
        end else begin
            // restarts on every state change and when finish is first seen
            if (state_nx != state || fin_hit) wcnt <= '0;
            else if (wcnt != '1)              wcnt <= wcnt + WW'(1);

            if (start_ok) pair_idx <= '0;
            else if (state == S_WAIT_HI && bus.chip_end_mul && pair_idx != P_LAST)
                pair_idx <= pair_idx + 4'd1;

            if (state != S_WAIT_FIN)  fin_seen <= 1'b0;
            else if (bus.chip_finish) fin_seen <= 1'b1;

            if (enter_ser) begin
                lead    <= 1'b1;
                hi      <= 1'b0;
                ph_cnt  <= '0;
                bit_idx <= '0;
            end else if (state == S_SHIFT || state == S_READ) begin
                if (lead) begin
                    lead   <= 1'b0;
                    hi     <= 1'b1;
                    ph_cnt <= '0;
                end else if (!ph_end) begin
                    ph_cnt <= ph_cnt + PW'(1);
                end else begin
                    ph_cnt <= '0;
                    if (hi) begin
                        hi <= 1'b0;
                    end else begin
                        hi      <= 1'b1;
                        bit_idx <= bit_idx + 5'd1;
                    end
                end
            end

            // data advances at the end of a high phase, so it only moves while shift is low
            if (state == S_LOAD && bus.pair_valid) begin
                sh_a <= bus.op_a;
                sh_b <= bus.op_b;
            end else if (state == S_SHIFT && hi && ph_end) begin
                sh_a <= {sh_a[6:0], 1'b0};
                sh_b <= {sh_b[6:0], 1'b0};
            end
        end
    end

    // Result capture: shiftout is sampled the cycle before each rise, LSB first.
    always_ff @(posedge clock) begin
        if (reset) begin
            res_q   <= '0;
            carry_q <= 1'b0;
            rv_q    <= 1'b0;
        end else if (start_ok) begin
            res_q   <= '0;
            carry_q <= 1'b0;
            rv_q    <= 1'b0;
        end else begin
            if (fin_hit) carry_q <= bus.chip_carry;
            if (state == S_READ && (lead || (lo_end && !ser_done)))
                res_q <= {bus.chip_shiftout, res_q[19:1]};
            if (state == S_READ && ser_done) rv_q <= 1'b1;
        end
    end

    // Outputs decoded from registered state only, so reset clears them at the edge.
    always_comb begin
        bus.pair_ready   = (state == S_LOAD);
        bus.busy         = !(state == S_IDLE || state == S_DONE || state == S_ERR);
        bus.error        = (state == S_ERR);
        bus.result       = res_q;
        bus.result_carry = carry_q;
        bus.result_valid = rv_q;
        bus.chip_start   = (state == S_START);
        bus.chip_do_next = (state == S_NEXT);
        bus.chip_shift   = (state == S_SHIFT || state == S_READ) && hi;
        bus.chip_shift_a = (state == S_SHIFT) && sh_a[7];
        bus.chip_shift_b = (state == S_SHIFT) && sh_b[7];
    end
endmodule

// File: tb/tb_mac_host_driver.sv
// Bench for mac_host_driver: behavioural chip model, pin-waveform monitor,
// table of runs plus hand-written watchdog and mid-run reset sequences.
module tb_mac_host_driver;
    localparam int SH = 2;
    localparam int GD = 4;
    localparam int WD = 255;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    mac_host_driver_if bus();

    mac_host_driver #(.SHIFT_HOLD(SH), .GUARD(GD), .WDOG(WD)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [9:0][7:0] a;
        logic [9:0][7:0] b;
        int              stall_at;
        bit              noise;
        bit              carry;
        int              exp_res;
    } vec_t;

    vec_t       vt[7];
    logic [7:0] pa[10];
    logic [7:0] pb[10];

    // ---------------- chip model ----------------
    logic        m_rst = 1'b1;
    logic        tie_end = 1'b0;
    logic        cfg_carry = 1'b0;
    logic [7:0]  ma, mb;
    logic [20:0] macc, mrd;
    int          mn, mdly;
    logic        m_busy, m_end, m_fin, m_prev;

    always @(posedge clock) begin
        if (m_rst) begin
            ma <= '0; mb <= '0; macc <= '0; mrd <= '0; mn <= 0; mdly <= 0;
            m_busy <= 1'b0; m_end <= 1'b0; m_fin <= 1'b0; m_prev <= 1'b0;
        end else begin
            m_prev <= bus.chip_shift;
            if (bus.chip_shift && !m_prev) begin
                if (m_fin) mrd <= mrd >> 1;
                else begin
                    ma <= {ma[6:0], bus.chip_shift_a};
                    mb <= {mb[6:0], bus.chip_shift_b};
                end
            end
            if (bus.chip_start || bus.chip_do_next) begin
                m_end  <= 1'b0;
                m_busy <= 1'b1;
                mdly   <= int'($urandom_range(1, 6));
            end else if (m_busy) begin
                if (mdly == 0) begin
                    m_busy <= 1'b0;
                    m_end  <= 1'b1;
                    macc   <= macc + 21'(ma) * 21'(mb);
                    mn     <= mn + 1;
                    if (mn == 9) begin
                        m_fin <= 1'b1;
                        mrd   <= macc + 21'(ma) * 21'(mb);
                    end
                end else begin
                    mdly <= mdly - 1;
                end
            end
        end
    end

    assign bus.chip_end_mul  = tie_end ? 1'b1 : m_end;
    assign bus.chip_finish   = m_fin;
    assign bus.chip_shiftout = mrd[0];
    // carry pin only shows the configured value once finish is up
    assign bus.chip_carry    = m_fin ? cfg_carry : ~cfg_carry;

    // ---------------- pin monitor ----------------
    logic mon_clr = 1'b1;
    int   n_start, n_next, b2b, hold_bad, data_bad, lat_bad, hi_len;
    logic p_shift, p_pulse, acc_d1, acc_d2;
    logic [1:0] p_ab;

    always @(posedge clock) begin
        if (mon_clr) begin
            n_start <= 0; n_next <= 0; b2b <= 0; hold_bad <= 0;
            data_bad <= 0; lat_bad <= 0; hi_len <= 0;
            acc_d1 <= 1'b0; acc_d2 <= 1'b0;
        end else begin
            if (bus.chip_start)   n_start <= n_start + 1;
            if (bus.chip_do_next) n_next  <= n_next + 1;
            if ((bus.chip_start || bus.chip_do_next) && p_pulse) b2b <= b2b + 1;
            hi_len <= bus.chip_shift ? hi_len + 1 : 0;
            if (!bus.chip_shift && p_shift && hi_len != SH) hold_bad <= hold_bad + 1;
            if (bus.chip_shift && {bus.chip_shift_a, bus.chip_shift_b} != p_ab)
                data_bad <= data_bad + 1;
            acc_d1 <= bus.pair_valid && bus.pair_ready;
            acc_d2 <= acc_d1;
            if (acc_d1 && bus.chip_shift)  lat_bad <= lat_bad + 1;
            if (acc_d2 && !bus.chip_shift) lat_bad <= lat_bad + 1;
        end
        p_shift <= bus.chip_shift;
        p_pulse <= bus.chip_start || bus.chip_do_next;
        p_ab    <= {bus.chip_shift_a, bus.chip_shift_b};
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_to(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting, got no event, expected one", name);
    endtask

    function automatic logic [31:0] outs_vec();
        return 32'({bus.pair_ready, bus.result, bus.result_carry, bus.result_valid,
                    bus.busy, bus.error, bus.chip_start, bus.chip_shift_a,
                    bus.chip_shift_b, bus.chip_shift, bus.chip_do_next});
    endfunction

    function automatic int ref_sum(input logic [9:0][7:0] a, input logic [9:0][7:0] b);
        int s = 0;
        for (int i = 0; i < 10; i++) s += int'(a[i]) * int'(b[i]);
        return s;
    endfunction

    task automatic load_vec(input vec_t v);
        for (int i = 0; i < 10; i++) begin
            pa[i] = v.a[i];
            pb[i] = v.b[i];
        end
        cfg_carry = v.carry;
    endtask

    task automatic chip_reset();
        m_rst = 1'b1; mon_clr = 1'b1;
        @(negedge clock);
        m_rst = 1'b0; mon_clr = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start_req = 1'b1;
        @(negedge clock);
        bus.start_req = 1'b0;
    endtask

    task automatic feed_pair(input int k);
        int budget = 0;
        repeat ($urandom_range(0, 2)) @(negedge clock);
        bus.op_a = pa[k];
        bus.op_b = pb[k];
        bus.pair_valid = 1'b1;
        while (bus.pair_ready !== 1'b1 && budget < 2000) begin
            @(negedge clock);
            budget++;
        end
        if (budget >= 2000) fail_to("pair_ready_wait");
        @(negedge clock);
        bus.pair_valid = 1'b0;
        bus.op_a = 8'($urandom);
        bus.op_b = 8'($urandom);
    endtask

    task automatic stall_check(input string tag);
        int budget = 0;
        int nn = 0;
        int drop = 0;
        while (bus.pair_ready !== 1'b1 && budget < 2000) begin
            @(negedge clock);
            budget++;
        end
        if (budget >= 2000) fail_to({tag, "_stall_ready_wait"});
        for (int c = 0; c < 200; c++) begin
            @(negedge clock);
            if (bus.chip_do_next) nn++;
            if (!bus.pair_ready) drop++;
        end
        check({tag, "_stall_do_next"}, nn, 0);
        check({tag, "_stall_ready"}, drop, 0);
    endtask

    task automatic run_job(input vec_t v, input string tag);
        int budget = 0;
        load_vec(v);
        chip_reset();
        pulse_start();
        check({tag, "_busy_run"}, 32'(bus.busy), 1);
        check({tag, "_rv_cleared"}, 32'(bus.result_valid), 0);
        for (int k = 0; k < 10; k++) begin
            if (k == v.stall_at) stall_check(tag);
            if (v.noise && k == 6) pulse_start();
            feed_pair(k);
        end
        while (bus.result_valid !== 1'b1 && budget < 3000) begin
            @(negedge clock);
            budget++;
        end
        if (budget >= 3000) fail_to({tag, "_result_valid_wait"});
        check({tag, "_result"},   32'(bus.result), 32'(v.exp_res));
        check({tag, "_carry"},    32'(bus.result_carry), 32'(v.carry));
        check({tag, "_rv"},       32'(bus.result_valid), 1);
        check({tag, "_busy_end"}, 32'(bus.busy), 0);
        check({tag, "_error"},    32'(bus.error), 0);
        check({tag, "_n_start"},  n_start, 1);
        check({tag, "_n_next"},   n_next, 9);
        check({tag, "_shift_hold"}, hold_bad, 0);
        check({tag, "_data_stable"}, data_bad, 0);
        check({tag, "_accept_lat"}, lat_bad, 0);
        check({tag, "_b2b_pulse"}, b2b, 0);
        repeat (3) @(negedge clock);
        check({tag, "_rv_hold"}, 32'(bus.result_valid), 1);
        check({tag, "_result_hold"}, 32'(bus.result), 32'(v.exp_res));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int budget;
        int cnt;
        bus.start_req = 1'b0;
        bus.pair_valid = 1'b0;
        bus.op_a = '0;
        bus.op_b = '0;

        repeat (3) @(negedge clock);
        check("reset_outs", outs_vec(), 0);
        reset = 1'b0;
        @(negedge clock);
        check("idle_outs", outs_vec(), 0);

        for (int i = 0; i < 10; i++) begin
            vt[0].a[i] = 8'(i + 2);  vt[0].b[i] = 8'(i + 3);
            vt[1].a[i] = 8'd255;     vt[1].b[i] = 8'd255;
            vt[2].a[i] = 8'd0;       vt[2].b[i] = 8'd0;
            vt[3].a[i] = 8'(i + 2);  vt[3].b[i] = 8'(i + 3);
        end
        vt[0].exp_res = 570;    vt[0].stall_at = -1; vt[0].noise = 1'b0; vt[0].carry = 1'b0;
        vt[1].exp_res = 650250; vt[1].stall_at = -1; vt[1].noise = 1'b0; vt[1].carry = 1'b0;
        vt[2].exp_res = 0;      vt[2].stall_at = -1; vt[2].noise = 1'b0; vt[2].carry = 1'b0;
        vt[3].exp_res = 570;    vt[3].stall_at = 5;  vt[3].noise = 1'b0; vt[3].carry = 1'b0;
        for (int t = 4; t < 7; t++) begin
            for (int i = 0; i < 10; i++) begin
                vt[t].a[i] = 8'($urandom);
                vt[t].b[i] = 8'($urandom);
            end
            vt[t].stall_at = -1;
            vt[t].noise    = 1'b1;
            vt[t].carry    = 1'($urandom_range(0, 1));
            vt[t].exp_res  = ref_sum(vt[t].a, vt[t].b);
        end

        for (int t = 0; t < 7; t++) run_job(vt[t], $sformatf("vec%0d", t));

        // watchdog: end-mul stuck high after the start pulse
        load_vec(vt[0]);
        chip_reset();
        tie_end = 1'b1;
        pulse_start();
        feed_pair(0);
        budget = 0;
        while (bus.chip_start !== 1'b1 && budget < 200) begin
            @(negedge clock);
            budget++;
        end
        if (budget >= 200) fail_to("wdog_start_wait");
        cnt = 0;
        while (bus.error !== 1'b1 && cnt < 1000) begin
            @(negedge clock);
            cnt++;
        end
        check("wdog_cycles", cnt, WD + 2);
        check("wdog_pins", 32'({bus.chip_start, bus.chip_shift_a, bus.chip_shift_b,
                                bus.chip_shift, bus.chip_do_next}), 0);
        check("wdog_busy", 32'(bus.busy), 0);
        repeat (5) @(negedge clock);
        check("wdog_sticky", 32'(bus.error), 1);
        tie_end = 1'b0;
        run_job(vt[0], "err_restart");

        // reset in the middle of pair 3's shift-in
        load_vec(vt[0]);
        chip_reset();
        pulse_start();
        for (int k = 0; k < 4; k++) feed_pair(k);
        repeat (3) @(negedge clock);
        check("rst_pre_busy", 32'(bus.busy), 1);
        reset = 1'b1;
        @(negedge clock);
        check("rst_mid_outs", outs_vec(), 0);
        reset = 1'b0;
        @(negedge clock);
        run_job(vt[0], "rst_rerun");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mac_host_driver.md
# mac_host_driver

Host-side sequencer for the serial MAC chip pin protocol. It accepts ten 8-bit operand pairs over a valid/ready interface and serializes each pair onto the chip's shift-A/shift-B/shift pins. It issues the start and do-next strobes, tracks multiply completion through the chip's end-mul and finish pins, and then shifts the 20-bit accumulated result back out. It sits between an on-board controller or test harness and the MAC chip's io pins.

## Interface
Parameters:
- SHIFT_HOLD, 2: cycles `chip_shift` is held high, then low, per bit (≥1).
- GUARD, 4: cycles waited after end-mul rises before the next do-next (≥2).
- WDOG, 255: maximum cycles spent in any wait state before error.
- N_PAIRS is a localparam fixed at 10, matching the chip's product count.

Ports:
- clock  in  1  single clock; every register is on posedge.
- reset  in  1  synchronous, active-high.
- start_req  in  1  begins a run; honored only in IDLE.
- pair_valid  in  1  operand pair offered.
- pair_ready  out  1  driver accepts the pair; a transfer occurs when valid & ready.
- op_a, op_b  in  8 each  operand pair.
- result  out  20  accumulated sum; LSB-first shift-out assembled.
- result_carry  out  1  chip carry, captured at finish.
- result_valid  out  1  result held valid.
- busy  out  1  run in progress.
- error  out  1  watchdog expired; sticky.
- chip_start, chip_shift_a, chip_shift_b, chip_shift, chip_do_next  out  1 each  chip pins.
- chip_finish, chip_end_mul, chip_shiftout, chip_carry  in  1 each  chip pins.

## Operation
- Reset: all outputs are 0; the FSM goes to IDLE; the pair index and counters clear. The chip's own reset is driven externally.
- FSM states:
  - IDLE: on start_req, clear result_valid and error, set busy, go to LOAD.
  - LOAD: pair_ready=1. On transfer, latch op_a/op_b and go to SHIFT.
  - SHIFT: 8 bits, MSB first. For bit i, chip_shift_a=op_a[7-i] and chip_shift_b=op_b[7-i]. Then chip_shift is high for SHIFT_HOLD cycles and low for SHIFT_HOLD cycles. Data pins change only while chip_shift=0. Exit: pair 0 goes to START_P; other pairs go to NEXT_P.
  - START_P / NEXT_P: chip_start (or chip_do_next) high for exactly 1 cycle, then go to WAIT_LO.
  - WAIT_LO: wait for chip_end_mul=0, then go to WAIT_HI.
  - WAIT_HI: wait for chip_end_mul=1. If the pair index is below 9, increment the index and go to GUARD. If the index is 9, go to WAIT_FIN.
  - GUARD: wait GUARD cycles, then go to LOAD.
  - WAIT_FIN: wait for chip_finish=1. Capture chip_carry into result_carry. Wait 2 more cycles so the chip's result load completes, then go to READ.
  - READ: 20 bits. For bit j, sample chip_shiftout into result[j] in the cycle before chip_shift rises. Then pulse chip_shift with the same SHIFT_HOLD high/low waveform. After bit 19, go to DONE.
  - DONE: result_valid=1, busy=0, go to IDLE. result and result_valid hold until the next accepted start_req.
- Watchdog: a counter resets on entry to each wait state (WAIT_LO, WAIT_HI, WAIT_FIN). If it exceeds WDOG, go to ERR.
- ERR: error=1, busy=0, all chip pins 0. Leave ERR on start_req, which is treated as from IDLE.
- start_req outside IDLE and ERR is ignored.
- pair_valid is ignored outside LOAD.
- Backpressure in LOAD has no timeout: the chip waits indefinitely for do-next.
- Reset mid-run: all outputs return to 0 at the next edge. Any chip pin that is high deasserts at that edge.

## Timing
- Pair accept to first chip_shift rise: 1 cycle (data is set up while shift=0).
- Shift-in duration: 16·SHIFT_HOLD cycles. Shift-out duration: 40·SHIFT_HOLD cycles.
- The chip samples the shift rising edge, so high and low phases must each be ≥1 cycle, which SHIFT_HOLD ≥1 guarantees.
- chip_start and chip_do_next are single-cycle pulses, never back-to-back.
- The do-next rising edge reaches the chip only after end-mul has been seen rising and GUARD cycles have elapsed. This ensures the chip is in its wait-next state.
- result_valid rises the cycle after the 20th bit's low phase ends.

## Test plan
- Pairs (i+2, i+3), i=0..9, SHIFT_HOLD=2 -> result=570, result_carry=0, result_valid=1, busy=0, error=0.
- Ten pairs (255, 255) -> result=650250, result_carry=0. Ten pairs (0, 0) -> result=0.
- Hold pair_valid low for 200 cycles before pair 5 -> no chip_do_next during the stall; final result is still 570.
- Tie chip_end_mul=1 (chip model stalled) -> error=1 exactly WDOG+1 cycles after WAIT_LO entry; all chip pins 0.
- Assert reset during pair 3's SHIFT -> next cycle all outputs are 0. Reset the chip, rerun the first scenario -> result=570.
- Pin-waveform check across a run:
  - chip_shift high phases are exactly SHIFT_HOLD cycles.
  - chip_shift_a/b never change while chip_shift=1.
  - Exactly one chip_start pulse and nine chip_do_next pulses occur.
